ball_event_detector: RTL and testbench

Per-ball event source for the game controller. It monitors one ball's velocity and its pixel overlap with the pocket drawing layer, once per video frame. It produces the events the controller consumes: `ballStopped` (level), `ballHoleHit` (one-cycle pulse) and `ballHoleNum`. One instance is placed per ball (white, red), between the ball physics/draw blocks and `game_controller`.

---
 rtl/billiard_pkg.sv | 15 +
 rtl/frame_overlap_counter.sv | 36 +++
 rtl/ball_event_detector.sv | 93 +++++++++
 tb/tb_ball_event_detector.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/billiard_pkg.sv
// billiard_pkg: shared types and helpers for the billiard ball event blocks
package billiard_pkg;
  typedef logic [2:0] hole_num_t;
  localparam int        NUM_HOLES = 6;
  localparam hole_num_t HOLE_NONE = 3'd0;
  typedef enum logic [1:0] {
    S_MOVING,
    S_SETTLING,
    S_STOPPED,
    S_POCKETED
  } ball_evt_state_t;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/frame_overlap_counter.sv
// frame_overlap_counter: saturating per-frame pixel coincidence counter with first-hit index capture
// Ports: clk, resetN (async, active-low); i_sof frame start pulse; i_clr clears the count;
//        i_hit coincidence on the current pixel; i_idx index owning that pixel;
//        o_cnt coincidences so far this frame; o_idx index of the first coincidence.
module frame_overlap_counter
  import billiard_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       i_sof,
  input  logic       i_clr,
  input  logic       i_hit,
  input  hole_num_t  i_idx,
  output logic [7:0] o_cnt,
  output hole_num_t  o_idx
);
  logic [7:0] r_cnt;
  hole_num_t  r_idx;
  // A pixel coincident with i_sof already belongs to the new frame.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_cnt <= 8'd0;
      r_idx <= HOLE_NONE;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
      r_idx <= HOLE_NONE;
    end else if (i_sof) begin
      r_cnt <= {7'd0, i_hit};
      r_idx <= i_hit ? i_idx : HOLE_NONE;
    end else if (i_hit) begin
      r_cnt <= sat_inc8(r_cnt);
      r_idx <= (r_cnt == 8'd0) ? i_idx : r_idx;
    end
  assign o_cnt = r_cnt;
  assign o_idx = r_idx;
endmodule

// File: rtl/ball_event_detector.sv
// ball_event_detector: per-ball stop / pocket event source for game_controller
// Ports: clk, resetN (async, active-low); startOfFrame, enterPressed one-cycle pulses;
//        ballShow ball visible; speedX/speedY signed velocity; ballDR/holeDR/holeNumPix
//        per-pixel overlap inputs; ballStopped rest level; ballHoleHit one-cycle pocket
//        pulse; ballHoleNum hole of the last pocket event.
module ball_event_detector
  import billiard_pkg::*;
#(
  parameter int SPEED_W     = 10,
  parameter int STOP_FRAMES = 4,
  parameter int OVERLAP_MIN = 8
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      enterPressed,
  input  logic                      ballShow,
  input  logic signed [SPEED_W-1:0] speedX,
  input  logic signed [SPEED_W-1:0] speedY,
  input  logic                      ballDR,
  input  logic                      holeDR,
  input  hole_num_t                 holeNumPix,
  output logic                      ballStopped,
  output logic                      ballHoleHit,
  output hole_num_t                 ballHoleNum
);
  localparam logic [3:0] STOP_N  = 4'(STOP_FRAMES);
  localparam logic [7:0] OVL_MIN = 8'(OVERLAP_MIN);
  ball_evt_state_t r_state, w_nxt_state;
  logic [3:0]      r_still, w_nxt_still, w_still_inc;
  logic            r_show_d, r_stopped, r_hit;
  hole_num_t       r_num, w_cap;
  logic [7:0]      w_cnt;
  logic            w_rise, w_live, w_zero, w_pocket;
  assign w_rise      = ballShow && !r_show_d;
  assign w_live      = r_state != S_POCKETED;
  assign w_zero      = (speedX == '0) && (speedY == '0);
  assign w_still_inc = r_still + 4'd1;
  frame_overlap_counter u_ovl (
    .clk   (clk),
    .resetN(resetN),
    .i_sof (startOfFrame),
    .i_clr (w_rise),
    .i_hit (ballDR && holeDR),
    .i_idx (holeNumPix),
    .o_cnt (w_cnt),
    .o_idx (w_cap)
  );
  // Priority: re-show leaves pocket, then hidden, then pocket, then shot, then speed rules.
  // A shot beats a coincident stop evaluation but not a coincident pocket.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_still = r_still;
    w_pocket    = 1'b0;
    if (w_rise && !w_live) begin
      w_nxt_state = S_STOPPED;
      w_nxt_still = STOP_N;
    end else if (startOfFrame && !ballShow) begin
      w_nxt_state = S_POCKETED;
    end else if (startOfFrame && w_live && w_cnt >= OVL_MIN) begin
      w_nxt_state = S_POCKETED;
      w_pocket    = 1'b1;
    end else if (w_live && (enterPressed || (startOfFrame && !w_zero))) begin
      w_nxt_state = S_MOVING;
      w_nxt_still = 4'd0;
    end else if (startOfFrame && r_state == S_MOVING) begin
      w_nxt_still = 4'd1;
      w_nxt_state = (STOP_N == 4'd1) ? S_STOPPED : S_SETTLING;
    end else if (startOfFrame && r_state == S_SETTLING) begin
      w_nxt_still = w_still_inc;
      w_nxt_state = (w_still_inc == STOP_N) ? S_STOPPED : S_SETTLING;
    end
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_state   <= S_STOPPED;
      r_still   <= STOP_N;
      r_show_d  <= 1'b1;
      r_stopped <= 1'b1;
      r_hit     <= 1'b0;
      r_num     <= HOLE_NONE;
    end else begin
      r_state   <= w_nxt_state;
      r_still   <= w_nxt_still;
      r_show_d  <= ballShow;
      r_stopped <= w_nxt_state == S_STOPPED;
      r_hit     <= w_pocket;
      r_num     <= w_pocket ? w_cap : r_num;
    end
  assign ballStopped = r_stopped;
  assign ballHoleHit = r_hit;
  assign ballHoleNum = r_num;
endmodule

// File: tb/tb_ball_event_detector.sv
// tb_ball_event_detector: scoreboard bench with a frame-level reference model
module tb_ball_event_detector;
  localparam int STOP = 4;
  localparam int OVL  = 8;
  typedef struct packed {
    logic       stopped;
    logic       hit;
    logic [2:0] num;
  } exp_t;
  logic              clk = 1'b0, resetN = 1'b0;
  logic              startOfFrame = 1'b0, enterPressed = 1'b0, ballShow = 1'b1;
  logic signed [9:0] speedX = '0, speedY = '0;
  logic              ballDR = 1'b0, holeDR = 1'b0;
  logic [2:0]        holeNumPix = '0;
  logic              ballStopped, ballHoleHit;
  logic [2:0]        ballHoleNum;
  int   n_chk = 0, n_err = 0;
  exp_t q[$];
  logic mon_en = 1'b0;
  logic d_show = 1'b1;
  // reference model: stopped means "STOP or more zero-speed frames since the last motion"
  int         m_zero_run, m_pix;
  logic       m_pocketed, m_prev_show;
  logic [2:0] m_hole, m_num;
  ball_event_detector dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enterPressed(enterPressed),
    .ballShow(ballShow), .speedX(speedX), .speedY(speedY), .ballDR(ballDR), .holeDR(holeDR),
    .holeNumPix(holeNumPix), .ballStopped(ballStopped), .ballHoleHit(ballHoleHit),
    .ballHoleNum(ballHoleNum)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_zero_run = STOP; m_pix = 0; m_pocketed = 1'b0; m_prev_show = 1'b1;
    m_hole = 3'd0; m_num = 3'd0;
  endtask
  task automatic model_step(input logic sof, ent, show, input int sx, sy,
                            input logic ovl, input logic [2:0] hole);
    exp_t e;
    logic hit = 1'b0;
    logic rise = show && !m_prev_show;
    if (rise && m_pocketed) begin
      m_pocketed = 1'b0;
      m_zero_run = STOP;
    end else if (sof && !show) m_pocketed = 1'b1;
    else if (sof && !m_pocketed && m_pix >= OVL) begin
      m_pocketed = 1'b1;
      hit = 1'b1;
      m_num = m_hole;
    end else if (!m_pocketed && ent) m_zero_run = 0;
    else if (sof && !m_pocketed)
      m_zero_run = (sx == 0 && sy == 0) ? ((m_zero_run < STOP) ? m_zero_run + 1 : STOP) : 0;
    if (rise) begin
      m_pix = 0; m_hole = 3'd0;
    end else if (sof) begin
      m_pix = ovl ? 1 : 0; m_hole = ovl ? hole : 3'd0;
    end else if (ovl) begin
      if (m_pix == 0) m_hole = hole;
      m_pix++;
    end
    m_prev_show = show;
    e.stopped = !m_pocketed && m_zero_run >= STOP;
    e.hit = hit;
    e.num = m_num;
    q.push_back(e);
  endtask
  task automatic cyc(input logic sof, ent, show, input int sx, sy,
                     input logic bdr, hdr, input logic [2:0] hole);
    @(negedge clk);
    startOfFrame = sof; enterPressed = ent; ballShow = show;
    speedX = 10'(sx); speedY = 10'(sy);
    ballDR = bdr; holeDR = hdr; holeNumPix = hole;
    model_step(sof, ent, show, sx, sy, bdr && hdr, hole);
    mon_en = 1'b1;
  endtask
  // 30-cycle frame: sof at cycle 0, npix overlap pixels from cycle 2, two ball-only pixels after
  task automatic frame(input int sx, sy, input logic show, input int npix,
                       input logic [2:0] hole, input int enter_at, input logic sof_ovl);
    for (int c = 0; c < 30; c++) begin
      logic hdr = (c == 0 && sof_ovl) || (c >= 2 && c < 2 + npix);
      logic bdr = hdr || (c >= 2 && c < 4 + npix);
      if (c == 1) d_show = show;
      cyc(c == 0, c == enter_at, d_show, sx, sy, bdr, hdr, hole);
    end
  endtask
  task automatic drain();
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("queue_empty", 8'(q.size()), 8'd0);
  endtask
  always @(posedge clk)
    if (mon_en) begin
      exp_t e;
      #1;
      if (q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL scoreboard_underflow: got no expectation at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("ballStopped", 8'(ballStopped), 8'(e.stopped));
        chk("ballHoleHit", 8'(ballHoleHit), 8'(e.hit));
        chk("ballHoleNum", 8'(ballHoleNum), 8'(e.num));
      end
    end
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_stopped", 8'(ballStopped), 8'd1);
    chk("reset_hit", 8'(ballHoleHit), 8'd0);
    chk("reset_num", 8'(ballHoleNum), 8'd0);
    resetN = 1'b1;
    repeat (3) frame(0, 0, 1, 0, 0, -1, 0);
    frame(5, -3, 1, 0, 0, 3, 0);
    frame(5, -3, 1, 0, 0, -1, 0);
    repeat (5) frame(0, 0, 1, 0, 0, -1, 0);
    frame(5, -3, 1, 7, 2, -1, 0);
    frame(5, -3, 1, 10, 3, -1, 0);
    frame(5, -3, 1, 10, 3, -1, 0);
    frame(0, 0, 1, 10, 3, -1, 0);
    frame(0, 0, 0, 20, 4, -1, 0);
    frame(0, 0, 0, 0, 0, -1, 0);
    frame(0, 0, 1, 0, 0, -1, 0);
    frame(0, 0, 1, 8, 5, -1, 0);
    frame(0, 0, 1, 0, 0, -1, 0);
    frame(0, 0, 0, 0, 0, -1, 0);
    frame(0, 0, 1, 0, 0, -1, 0);
    frame(0, 0, 1, 0, 0, 0, 0);
    frame(0, 0, 1, 0, 0, -1, 0);
    frame(5, 0, 1, 7, 1, -1, 0);
    frame(5, 0, 1, 7, 6, -1, 1);
    frame(5, 0, 1, 0, 0, -1, 0);
    frame(0, 0, 0, 0, 0, -1, 0);
    frame(0, 0, 1, 0, 0, -1, 0);
    for (int f = 0; f < 150; f++) begin
      int sx = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(0, 20)) - 10;
      int sy = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(0, 20)) - 10;
      logic show = $urandom_range(0, 9) != 0;
      int npix = $urandom_range(0, 12);
      logic [2:0] hole = 3'($urandom_range(1, 6));
      int ent = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 25)) : -1;
      frame(sx, sy, show, npix, hole, ent, $urandom_range(0, 7) == 0);
    end
    frame(3, 3, 1, 0, 0, -1, 0);
    frame(3, 3, 1, 0, 0, -1, 0);
    for (int c = 0; c < 6; c++) cyc(c == 0, 1'b0, 1'b1, 3, 3, c > 1, c > 1, 3'd2);
    drain();
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("midreset_stopped", 8'(ballStopped), 8'd1);
    chk("midreset_hit", 8'(ballHoleHit), 8'd0);
    chk("midreset_num", 8'(ballHoleNum), 8'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    model_reset();
    frame(0, 0, 1, 8, 4, -1, 0);
    frame(0, 0, 1, 0, 0, -1, 0);
    frame(0, 0, 1, 0, 0, -1, 0);
    drain();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
